// File: rtl/mult_exe_sequencer.sv
// EX-stage MULT sequencer: radix-2 shift-add multiply over WORD_LEN cycles,
// stalling the pipeline until the low product word is presented for one cycle.
module mult_exe_sequencer #(
  parameter int WORD_LEN = 32,
  parameter int EXE_CMD_LEN = 4,
  parameter logic [EXE_CMD_LEN-1:0] EXE_MULT_CODE = 4'b1010
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [EXE_CMD_LEN-1:0] exe_cmd,
  input  logic                   ex_valid,
  input  logic                   flush,
  input  logic [WORD_LEN-1:0]    val1,
  input  logic [WORD_LEN-1:0]    val2,
  output logic                   stall,
  output logic [WORD_LEN-1:0]    result,
  output logic                   result_valid,
  output logic                   busy
);

  localparam int CNT_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WORD_LEN - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   counter;
  logic [WORD_LEN-1:0] acc;
  logic [WORD_LEN-1:0] mcand;
  logic [WORD_LEN-1:0] mplier;
  logic               start;

  assign start = ex_valid && (exe_cmd == EXE_MULT_CODE) && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      counter <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand   <= val1;
            mplier  <= val2;
            acc     <= '0;
            counter <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            if (mplier[0]) acc <= acc + mcand;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            counter <= counter + 1'b1;
            if (counter == LAST_ITER) state <= DONE;
          end
        end
        // The finished MULT is still in EX here, so never restart from DONE.
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stall is masked during reset because start is combinational on the inputs.
  assign stall = rst && (((state == IDLE) && start) || ((state == BUSY) && !flush));
  assign result = acc;
  assign result_valid = (state == DONE) && !flush;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mult_exe_sequencer.sv
// Randomised bench for mult_exe_sequencer, checked against a cycle-timing and
// truncated-product reference model.
module tb_mult_exe_sequencer;

  localparam int W = 32;
  localparam logic [3:0] MULT = 4'b1010;
  localparam logic [3:0] ADD = 4'b0000;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   exe_cmd = '0;
  logic         ex_valid = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] val1 = '0;
  logic [W-1:0] val2 = '0;
  logic         stall;
  logic [W-1:0] result;
  logic         result_valid;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;

  mult_exe_sequencer #(.WORD_LEN(W), .EXE_CMD_LEN(4), .EXE_MULT_CODE(MULT)) dut (
    .clk(clk), .rst(rst), .exe_cmd(exe_cmd), .ex_valid(ex_valid), .flush(flush),
    .val1(val1), .val2(val2), .stall(stall), .result(result),
    .result_valid(result_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic ev, input logic [3:0] cmd, input logic fl,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    ex_valid = ev;
    exe_cmd = cmd;
    flush = fl;
    val1 = a;
    val2 = b;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ex_valid = 1'b1;
    exe_cmd = MULT;
    val1 = 32'd3;
    val2 = 32'd5;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({stall, result_valid, busy} !== 3'b000 || result !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got stall=%b rv=%b busy=%b result=%h exp all zero",
               stall, result_valid, busy, result);
    end
    @(negedge clk);
    ex_valid = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_multiply();
    logic [W-1:0] ta[$];
    logic [W-1:0] tb[$];
    logic [W-1:0] expected;
    ta = '{32'd3, 32'hFFFF_FFFE, 32'h0001_0000, 32'hFFFF_FFFF, 32'd9};
    tb = '{32'd5, 32'd7, 32'h0001_0000, 32'hFFFF_FFFF, 32'd9};
    for (int r = 0; r < 6; r++) begin
      ta.push_back($urandom);
      tb.push_back($urandom);
    end
    for (int k = 0; k < ta.size(); k++) begin
      expected = ta[k] * tb[k];
      // After cycle 0 the operand buses carry unrelated forwarding traffic.
      for (int cyc = 0; cyc <= W + 1; cyc++) begin
        if (cyc == 0) drive(1'b1, MULT, 1'b0, ta[k], tb[k]);
        else drive(1'b1, MULT, 1'b0, $urandom, $urandom);
        vectors++;
        if (stall !== (cyc <= W)) begin
          miscompares++;
          $display("FAIL mul_stall op=%0d cyc=%0d got=%b exp=%b", k, cyc, stall, cyc <= W);
        end
        vectors++;
        if (result_valid !== (cyc == W + 1)) begin
          miscompares++;
          $display("FAIL mul_rv op=%0d cyc=%0d got=%b exp=%b", k, cyc, result_valid, cyc == W + 1);
        end
        vectors++;
        if (busy !== (cyc >= 1)) begin
          miscompares++;
          $display("FAIL mul_busy op=%0d cyc=%0d got=%b exp=%b", k, cyc, busy, cyc >= 1);
        end
        if (cyc == W + 1) begin
          vectors++;
          if (result !== expected) begin
            miscompares++;
            $display("FAIL mul_result op=%0d %h*%h got=%h exp=%h", k, ta[k], tb[k], result, expected);
          end
        end
      end
      drive(1'b0, MULT, 1'b0, '0, '0);
      vectors++;
      if (busy !== 1'b0 || stall !== 1'b0) begin
        miscompares++;
        $display("FAIL mul_idle_after op=%0d got busy=%b stall=%b exp 0 0", k, busy, stall);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a [2];
    logic [W-1:0] b [2];
    int pulses;
    int first_pulse;
    int gap;
    logic prev_rv;
    a = '{32'd4, 32'd6};
    b = '{32'd4, 32'd7};
    pulses = 0;
    first_pulse = -1;
    gap = -1;
    prev_rv = 1'b0;
    for (int cyc = 0; cyc < 2 * (W + 2); cyc++) begin
      int ph;
      int loc;
      ph = cyc / (W + 2);
      loc = cyc % (W + 2);
      if (loc == 0) drive(1'b1, MULT, 1'b0, a[ph], b[ph]);
      else drive(1'b1, MULT, 1'b0, $urandom, $urandom);
      vectors++;
      if (result_valid !== (loc == W + 1) || stall !== (loc <= W)) begin
        miscompares++;
        $display("FAIL b2b_timing cyc=%0d got rv=%b stall=%b exp rv=%b stall=%b",
                 cyc, result_valid, stall, loc == W + 1, loc <= W);
      end
      if (result_valid === 1'b1) begin
        vectors++;
        if (prev_rv === 1'b1) begin
          miscompares++;
          $display("FAIL b2b_consecutive cyc=%0d got rv high twice exp single pulse", cyc);
        end
        vectors++;
        if (result !== a[pulses % 2] * b[pulses % 2]) begin
          miscompares++;
          $display("FAIL b2b_result pulse=%0d got=%h exp=%h", pulses, result,
                   a[pulses % 2] * b[pulses % 2]);
        end
        if (pulses == 0) first_pulse = cyc;
        else if (pulses == 1) gap = cyc - first_pulse;
        pulses++;
      end
      prev_rv = result_valid;
    end
    drive(1'b0, MULT, 1'b0, '0, '0);
    vectors++;
    if (pulses != 2 || gap != W + 2) begin
      miscompares++;
      $display("FAIL b2b_pulses got count=%0d gap=%0d exp count=2 gap=%0d", pulses, gap, W + 2);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, MULT, 1'b0, 32'd11, 32'd13);
    for (int cyc = 1; cyc < 5; cyc++) drive(1'b1, MULT, 1'b0, 32'd11, 32'd13);
    drive(1'b1, MULT, 1'b1, 32'd11, 32'd13);
    vectors++;
    if (stall !== 1'b0 || result_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_busy_same got stall=%b rv=%b exp 0 0", stall, result_valid);
    end
    drive(1'b0, ADD, 1'b0, '0, '0);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_busy_next got busy=%b exp 0", busy);
    end
    for (int cyc = 0; cyc < W + 4; cyc++) begin
      drive(1'b0, ADD, 1'b0, '0, '0);
      vectors++;
      if (result_valid !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL flush_no_result cyc=%0d got rv=%b busy=%b exp 0 0", cyc, result_valid, busy);
      end
    end
    drive(1'b1, MULT, 1'b1, 32'd2, 32'd2);
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_idle_stall got=%b exp=0", stall);
    end
    drive(1'b0, ADD, 1'b0, '0, '0);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_idle_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, MULT, 1'b0, 32'd21, 32'd2);
    for (int cyc = 1; cyc < 20; cyc++) drive(1'b1, MULT, 1'b0, 32'd21, 32'd2);
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if ({stall, result_valid, busy} !== 3'b000 || result !== '0) begin
      miscompares++;
      $display("FAIL reset_mid got stall=%b rv=%b busy=%b result=%h exp all zero",
               stall, result_valid, busy, result);
    end
    @(negedge clk);
    ex_valid = 1'b0;
    rst = 1'b1;
    for (int cyc = 0; cyc < W + 4; cyc++) begin
      drive(1'b0, ADD, 1'b0, '0, '0);
      vectors++;
      if (result_valid !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_mid_after cyc=%0d got rv=%b busy=%b exp 0 0", cyc, result_valid, busy);
      end
    end
  endtask

  task automatic test_non_mult();
    logic [3:0] cmd;
    drive(1'b1, ADD, 1'b0, 32'd1, 32'd2);
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL add_stall got=%b exp=0", stall);
    end
    for (int cyc = 0; cyc < 30; cyc++) begin
      logic ev;
      cmd = 4'($urandom_range(0, 15));
      if (cmd == MULT) cmd = ADD;
      ev = 1'($urandom);
      if (cyc % 3 == 0) begin
        cmd = MULT;
        ev = 1'b0;
      end
      drive(ev, cmd, 1'b0, $urandom, $urandom);
      vectors++;
      if (stall !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL non_mult cyc=%0d cmd=%h ev=%b got stall=%b busy=%b exp 0 0",
                 cyc, cmd, ev, stall, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_non_mult();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
